fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one synchronous memory read per
// cycle and buffers returned instructions in a prefetch queue for decode.
module fetch_unit #(
  parameter int INSTR_W = 30,
  parameter int PC_W    = 8,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_en,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [PC_W-1:0]    fetchPc_q, fetchPc_d;
  logic               pendValid_q, pendValid_d;
  logic [PC_W-1:0]    pendPc_q, pendPc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instrMem_q [DEPTH];
  logic [PC_W-1:0]    pcMem_q [DEPTH];
  logic [OCC_W-1:0]   credit;
  logic               push, pop;

  // The in-flight read reserves a slot, so a landing return can never overflow.
  assign credit    = {1'b0, count_q} + {{CNT_W{1'b0}}, pendValid_q};
  assign imem_en   = rst_n & ~halt & ~redirect_valid & (credit < OCC_W'(DEPTH));
  assign imem_addr = fetchPc_q;

  assign out_valid = (count_q != '0) & ~redirect_valid;
  assign out_instr = instrMem_q[head_q];
  assign out_pc    = pcMem_q[head_q];
  assign count     = count_q;

  assign push = pendValid_q & ~redirect_valid;
  assign pop  = out_valid & out_ready;

  // Redirect overrides everything: flush the queue, drop the return, retarget the PC.
  always_comb begin
    fetchPc_d   = fetchPc_q;
    pendValid_d = 1'b0;
    pendPc_d    = pendPc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (redirect_valid) begin
      fetchPc_d = redirect_pc;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      if (imem_en) begin
        fetchPc_d   = fetchPc_q + PC_W'(1);
        pendValid_d = 1'b1;
        pendPc_d    = fetchPc_q;
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q   <= '0;
      pendValid_q <= 1'b0;
      pendPc_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetchPc_q   <= fetchPc_d;
      pendValid_q <= pendValid_d;
      pendPc_q    <= pendPc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
      end
    end else if (push) begin
      instrMem_q[tail_q] <= imem_data;
      pcMem_q[tail_q]    <= pendPc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch stage.
module tb_fetch_unit;
  localparam int INSTR_W = 30;
  localparam int PC_W    = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               clk;
  logic               rst_n;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;
  logic [CNT_W-1:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch PC, one in-flight read, and a FIFO of PCs
  logic [PC_W-1:0] mPc;
  bit              mPend;
  logic [PC_W-1:0] mPendPc;
  logic [PC_W-1:0] mQ[$];

  fetch_unit #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory returns its own address, one cycle after the strobe
  always @(posedge clk) begin
    if (imem_en) imem_data <= INSTR_W'(imem_addr);
  end

  function automatic bit expEn();
    return rst_n && !halt && !redirect_valid && ((mQ.size() + int'(mPend)) < DEPTH);
  endfunction

  function automatic bit expValid();
    return (mQ.size() != 0) && !redirect_valid;
  endfunction

  task automatic modelReset();
    mQ.delete();
    mPc     = '0;
    mPend   = 1'b0;
    mPendPc = '0;
  endtask

  task automatic modelStep();
    bit issue;
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (redirect_valid) begin
      mQ.delete();
      mPc   = redirect_pc;
      mPend = 1'b0;
      return;
    end
    issue = expEn();
    if (expValid() && out_ready) void'(mQ.pop_front());
    if (mPend) mQ.push_back(mPendPc);
    mPend   = issue;
    mPendPc = mPc;
    if (issue) mPc = mPc + 8'd1;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input bit ready);
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = ready;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    modelReset();
    #1;
    checks++;
    if (imem_en !== 1'b0 || out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: en=%b valid=%b count=%0d, required 0/0/0", imem_en, out_valid, count);
    end
    checks++;
    if (out_pc !== '0 || out_instr !== '0 || imem_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: pc=%h instr=%h addr=%h, required all 0", out_pc, out_instr, imem_addr);
    end
  endtask

  task automatic test_startup();
    doReset(1'b1);
    for (int n = 0; n < 8; n++) begin
      #1;
      checks++;
      if (imem_en !== 1'b1 || imem_addr !== PC_W'(n)) begin
        errors++;
        $display("[TB] FAIL startup_issue cyc%0d: en=%b addr=%h, required 1/%h", n, imem_en, imem_addr, n);
      end
      checks++;
      if (n >= 2) begin
        if (out_valid !== 1'b1 || out_pc !== PC_W'(n - 2) || out_instr !== INSTR_W'(n - 2) || count !== CNT_W'(1)) begin
          errors++;
          $display("[TB] FAIL startup_out cyc%0d: valid=%b pc=%h count=%0d, required 1/%h/1", n, out_valid, out_pc, count, n - 2);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL startup_early cyc%0d: valid=%b, required 0", n, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    logic [PC_W-1:0] got[$];
    int firstIssue;
    doReset(1'b0);
    for (int n = 0; n < 8; n++) begin
      #1;
      checks++;
      if (imem_en !== (n < 4) || (n < 4 && imem_addr !== PC_W'(n))) begin
        errors++;
        $display("[TB] FAIL fill_issue cyc%0d: en=%b addr=%h, required en=%0d", n, imem_en, imem_addr, n < 4);
      end
      if (n >= 5) begin
        checks++;
        if (count !== CNT_W'(DEPTH)) begin
          errors++;
          $display("[TB] FAIL fill_count cyc%0d: count=%0d, required %0d", n, count, DEPTH);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    firstIssue = -1;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (out_valid) got.push_back(out_pc);
      if (imem_en && firstIssue < 0) firstIssue = int'(imem_addr);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== PC_W'(i)) begin
        errors++;
        $display("[TB] FAIL drain_order[%0d]: got %h, required %h", i, (got.size() > i) ? got[i] : 8'hxx, i);
      end
    end
    checks++;
    if (firstIssue != 4) begin
      errors++;
      $display("[TB] FAIL resume_addr: got %0d, required 4", firstIssue);
    end
  endtask

  task automatic test_redirect_flush();
    doReset(1'b0);
    for (int n = 0; n < 4; n++) begin
      #1;
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0 || count !== CNT_W'(3)) begin
      errors++;
      $display("[TB] FAIL redir_cycle: valid=%b en=%b count=%0d, required 0/0/3", out_valid, imem_en, count);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'h40) begin
      errors++;
      $display("[TB] FAIL redir_t1: count=%0d valid=%b en=%b addr=%h, required 0/0/1/40", count, out_valid, imem_en, imem_addr);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_t2: valid=%b, required 0", out_valid);
    end
    tick();
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== PC_W'(8'h40 + n)) begin
        errors++;
        $display("[TB] FAIL redir_deliver%0d: valid=%b pc=%h, required 1/%h", n, out_valid, out_pc, 8'h40 + n);
      end
      tick();
    end
  endtask

  task automatic test_redirect_wrap();
    logic [PC_W-1:0] got[$];
    logic [PC_W-1:0] want[4];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    #1;
    tick();
    redirect_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (out_valid) got.push_back(out_pc);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== want[i]) begin
        errors++;
        $display("[TB] FAIL wrap[%0d]: got %h, required %h", i, (got.size() > i) ? got[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    doReset(1'b0);
    for (int n = 0; n < 3; n++) begin
      #1;
      tick();
    end
    #1;
    checks++;
    if (count !== CNT_W'(2)) begin
      errors++;
      $display("[TB] FAIL areset_pre: count=%0d, required 2", count);
    end
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0 || count !== '0) begin
      errors++;
      $display("[TB] FAIL areset_now: valid=%b en=%b count=%0d, required 0/0/0", out_valid, imem_en, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== '0) begin
      errors++;
      $display("[TB] FAIL areset_restart: en=%b addr=%h, required 1/00", imem_en, imem_addr);
    end
    tick();
  endtask

  task automatic test_halt();
    logic [PC_W-1:0] seen[$];
    doReset(1'b1);
    for (int n = 0; n < 5; n++) begin
      #1;
      if (out_valid && out_ready) seen.push_back(out_pc);
      tick();
    end
    halt = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++;
      if (imem_en !== 1'b0 || imem_addr !== 8'h05) begin
        errors++;
        $display("[TB] FAIL halt_hold%0d: en=%b addr=%h, required 0/05", n, imem_en, imem_addr);
      end
      if (n == 5) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL halt_drain: valid=%b, required 0", out_valid);
        end
      end
      if (out_valid && out_ready) seen.push_back(out_pc);
      tick();
    end
    halt = 1'b0;
    #1;
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 8'h05) begin
      errors++;
      $display("[TB] FAIL halt_resume: en=%b addr=%h, required 1/05", imem_en, imem_addr);
    end
    for (int n = 0; n < 8; n++) begin
      if (n > 0) #1;
      if (out_valid && out_ready) seen.push_back(out_pc);
      tick();
    end
    checks++;
    if (seen.size() < 10) begin
      errors++;
      $display("[TB] FAIL halt_seq_len: got %0d, required at least 10", seen.size());
    end
    foreach (seen[i]) begin
      checks++;
      if (seen[i] !== PC_W'(i)) begin
        errors++;
        $display("[TB] FAIL halt_seq[%0d]: got %h, required %h", i, seen[i], i);
      end
    end
  endtask

  task automatic test_random();
    doReset(1'b1);
    for (int n = 0; n < 400; n++) begin
      halt           = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = PC_W'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (imem_en !== expEn() || (expEn() && imem_addr !== mPc)) begin
        errors++;
        $display("[TB] FAIL rand_issue cyc%0d: en=%b addr=%h, required %b/%h", n, imem_en, imem_addr, expEn(), mPc);
      end
      checks++;
      if (count !== CNT_W'(mQ.size()) || out_valid !== expValid()) begin
        errors++;
        $display("[TB] FAIL rand_occ cyc%0d: count=%0d valid=%b, required %0d/%b", n, count, out_valid, mQ.size(), expValid());
      end
      if (expValid()) begin
        checks++;
        if (out_pc !== mQ[0] || out_instr !== INSTR_W'(mQ[0])) begin
          errors++;
          $display("[TB] FAIL rand_head cyc%0d: pc=%h instr=%h, required %h", n, out_pc, out_instr, mQ[0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_fill_stall();
    test_redirect_flush();
    test_redirect_wrap();
    test_async_reset();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
